count_seq_checker: RTL and testbench



---
 rtl/count_seq_checker.sv | 126 ++++++++++++
 tb/tb_count_seq_checker.sv | 136 +++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// Sequence checker for a free-running +1 counter: locks after SYNC_LEN good steps,
// then flags/counts breaks and wraps. Optional macro COUNT_CHK_STICKY_EN makes errors sticky.
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 8,
    parameter int SYNC_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              count_vld,
    input  logic              dut_rst,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0]  exp_val
);

    localparam int RUN_W = (SYNC_LEN < 1) ? 1 : $clog2(SYNC_LEN + 1);

`ifdef COUNT_CHK_STICKY_EN
    typedef enum logic [1:0] {UNSYNC, SYNC, LOCK, ERROR} state_t;
`else
    typedef enum logic [1:0] {UNSYNC, SYNC, LOCK} state_t;
`endif

    state_t            state, state_n;
    logic [RUN_W-1:0]  run, run_n;
    logic              locked_n, err_pulse_n;
    logic [ERR_W-1:0]  err_cnt_n;
    logic [WRAP_W-1:0] wrap_cnt_n;
    logic [WIDTH-1:0]  exp_val_n;
    logic [WIDTH-1:0]  nxt;
    logic              active;

    assign nxt = count_in + WIDTH'(1);

`ifdef COUNT_CHK_STICKY_EN
    // ERROR ignores every sample, dut_rst included
    assign active = count_vld && (state != ERROR);
`else
    assign active = count_vld;
`endif

    always_comb begin
        state_n     = state;
        run_n       = run;
        locked_n    = locked;
        err_pulse_n = 1'b0;
        err_cnt_n   = err_cnt;
        wrap_cnt_n  = wrap_cnt;
        exp_val_n   = exp_val;
        if (active) begin
            if (dut_rst) begin
                if (state == LOCK && count_in != '0) begin
                    err_pulse_n = 1'b1;
                    err_cnt_n   = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);
                end
                exp_val_n = WIDTH'(1);
                run_n     = '0;
            end else begin
                case (state)
                    UNSYNC: begin
                        exp_val_n = nxt;
                        run_n     = '0;
                        state_n   = SYNC;
                    end
                    SYNC: begin
                        exp_val_n = nxt;
                        if (count_in == exp_val) begin
                            run_n = run + RUN_W'(1);
                            if (run == RUN_W'(SYNC_LEN - 1)) begin
                                state_n  = LOCK;
                                locked_n = 1'b1;
                            end
                        end else begin
                            run_n = '0;
                        end
                    end
                    LOCK: begin
                        if (count_in == exp_val) begin
                            exp_val_n = nxt;
                            if (count_in == '0)
                                wrap_cnt_n = (&wrap_cnt) ? wrap_cnt : wrap_cnt + WRAP_W'(1);
                        end else begin
                            err_pulse_n = 1'b1;
                            err_cnt_n   = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);
                            locked_n    = 1'b0;
`ifdef COUNT_CHK_STICKY_EN
                            state_n     = ERROR;
`else
                            state_n     = SYNC;
                            run_n       = '0;
                            exp_val_n   = nxt;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= UNSYNC;
            run       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            wrap_cnt  <= '0;
            exp_val   <= '0;
        end else begin
            state     <= state_n;
            run       <= run_n;
            locked    <= locked_n;
            err_pulse <= err_pulse_n;
            err_cnt   <= err_cnt_n;
            wrap_cnt  <= wrap_cnt_n;
            exp_val   <= exp_val_n;
        end
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker (ERR_W=2 so saturation is reachable).
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       rst, count_vld, dut_rst;
    logic [3:0] count_in;
    logic       locked, err_pulse;
    logic [1:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic [3:0] exp_val;

    count_seq_checker #(.WIDTH(4), .ERR_W(2), .WRAP_W(8), .SYNC_LEN(2)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .count_vld(count_vld),
        .dut_rst(dut_rst), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .exp_val(exp_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        bit         chk_lk;
        logic       lk;
        logic       ep;
        logic [1:0] ec;
        logic [7:0] wc;
        logic [3:0] ev;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   failed = 0;
    int   vec_n = 0;

    task automatic cmp(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s vec%0d: got %0d required %0d", name, idx, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle, one expectation per driven cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                if (e.chk_lk) cmp("locked", e.idx, {7'd0, locked}, {7'd0, e.lk});
                cmp("err_pulse", e.idx, {7'd0, err_pulse}, {7'd0, e.ep});
                cmp("err_cnt", e.idx, {6'd0, err_cnt}, {6'd0, e.ec});
                cmp("wrap_cnt", e.idx, wrap_cnt, e.wc);
                cmp("exp_val", e.idx, {4'd0, exp_val}, {4'd0, e.ev});
            end
        end
    end

    task automatic v(input logic r, input logic vl, input logic dr, input logic [3:0] c,
                     input bit chk_lk, input logic lk, input logic ep,
                     input logic [1:0] ec, input logic [7:0] wc, input logic [3:0] ev);
        exp_t e;
        @(negedge clk);
        rst = r; count_vld = vl; dut_rst = dr; count_in = c;
        e.idx = vec_n; e.chk_lk = chk_lk; e.lk = lk; e.ep = ep;
        e.ec = ec; e.wc = wc; e.ev = ev;
        q.push_back(e);
        vec_n++;
    endtask

    initial begin
        logic [3:0] e4;
        logic [1:0] ecs;
        rst = 1'b1; count_vld = 1'b0; dut_rst = 1'b0; count_in = '0;
        // reset state, then 0,1,2,3: lock after sample 2
        v(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        v(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        v(0, 1, 0, 1, 1, 0, 0, 0, 0, 2);
        v(0, 1, 0, 2, 1, 1, 0, 0, 0, 3);
        v(0, 1, 0, 3, 1, 1, 0, 0, 0, 4);
`ifdef COUNT_CHK_STICKY_EN
        v(0, 1, 0, 9, 1, 0, 1, 1, 0, 4);
        for (int i = 0; i <= 5; i++)
            v(0, 1, 0, 4'(i), 1, 0, 0, 1, 0, 4);
        v(0, 1, 1, 0, 1, 0, 0, 1, 0, 4);
        v(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
`else
        // run up through the 15->0 wrap
        for (int i = 4; i <= 15; i++)
            v(0, 1, 0, 4'(i), 1, 1, 0, 0, 0, 4'(i + 1));
        v(0, 1, 0, 0, 1, 1, 0, 0, 1, 1);
        v(0, 1, 0, 1, 1, 1, 0, 0, 1, 2);
        v(0, 0, 0, 9, 1, 1, 0, 0, 1, 2);
        // error at exp_val=5, then relock on 8,9
        v(0, 1, 0, 2, 1, 1, 0, 0, 1, 3);
        v(0, 1, 0, 3, 1, 1, 0, 0, 1, 4);
        v(0, 1, 0, 4, 1, 1, 0, 0, 1, 5);
        v(0, 1, 0, 7, 1, 0, 1, 1, 1, 8);
        v(0, 1, 0, 8, 1, 0, 0, 1, 1, 9);
        v(0, 1, 0, 9, 1, 1, 0, 1, 1, 10);
        // observed counter reset while locked
        v(0, 1, 1, 0, 1, 1, 0, 1, 1, 1);
        v(0, 1, 1, 0, 1, 1, 0, 1, 1, 1);
        v(0, 1, 0, 1, 1, 1, 0, 1, 1, 2);
        v(0, 1, 0, 2, 1, 1, 0, 1, 1, 3);
        v(0, 1, 1, 3, 0, 0, 1, 2, 1, 1);
        v(0, 0, 0, 0, 0, 0, 0, 2, 1, 1);
        // error counter saturation
        v(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        v(0, 1, 0, 1, 1, 0, 0, 0, 0, 2);
        v(0, 1, 0, 2, 1, 1, 0, 0, 0, 3);
        e4 = 4'd3;
        for (int k = 1; k <= 5; k++) begin
            ecs = (k > 3) ? 2'd3 : 2'(k);
            v(0, 1, 0, e4 + 4'd4, 1, 0, 1, ecs, 0, e4 + 4'd5);
            v(0, 1, 0, e4 + 4'd5, 1, 0, 0, ecs, 0, e4 + 4'd6);
            v(0, 1, 0, e4 + 4'd6, 1, 1, 0, ecs, 0, e4 + 4'd7);
            e4 = e4 + 4'd7;
        end
`endif
        @(negedge clk);
        count_vld = 1'b0;
        for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
        if (q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
